// File: rtl/lc3_dmem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_dmem_pkg
// Shared types and constants for the LC3 data-memory controller.
//   dmem_state_t : controller FSM states
//   OFF_WD       : block-offset width for the default block size
//   DEF_*        : default parameter values used by lc3_dmem_ctrl
//   LAT_WD       : width of the latency down-counter (latencies up to 15)
// ---------------------------------------------------------------------------
package lc3_dmem_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_BURST = 3'd2,
      WR_WAIT  = 3'd3,
      WR_ACK   = 3'd4
   } dmem_state_t;

   localparam int DEF_ADDR_WD     = 16;
   localparam int DEF_DATA_WD     = 16;
   localparam int DEF_BLOCK_WORDS = 4;
   localparam int DEF_READ_LAT    = 4;
   localparam int DEF_WRITE_LAT   = 2;
   localparam int DEF_MEM_AW      = 16;
   localparam int LAT_WD          = 4;

   localparam int OFF_WD = $clog2(DEF_BLOCK_WORDS);

   // Offset width for an arbitrary block size.
   function automatic int off_wd(input int block_words);
      return $clog2(block_words);
   endfunction

endpackage

// File: rtl/lc3_dmem_array.sv
// ---------------------------------------------------------------------------
// lc3_dmem_array
// Single-port word RAM backing the data-memory controller.
// Synchronous write, registered read. The read register is the controller's
// dout, so it is the only storage cleared by reset; the array itself is not.
//   clock : rising-edge clock
//   reset : asynchronous active-high, clears the read register only
//   en    : port enable
//   we    : write enable (with en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds when no read is performed
// ---------------------------------------------------------------------------
module lc3_dmem_array
   import lc3_dmem_pkg::*;
#(
   parameter int DATA_WD = DEF_DATA_WD,
   parameter int MEM_AW  = DEF_MEM_AW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               we,
   input  logic [MEM_AW-1:0]  addr,
   input  logic [DATA_WD-1:0] wdata,
   output logic [DATA_WD-1:0] rdata
);

   logic [DATA_WD-1:0] mem [0:(1<<MEM_AW)-1];

   always_ff @(posedge clock) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/lc3_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_dmem_ctrl
// Main-memory slave for the LC3 data cache. Serves block-refill reads
// (rrqst/rrdy, then a burst of BLOCK_WORDS beats paced by rdacpt) and
// write-through single-word writes (wrqst/wacpt) with configurable latency.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   rrqst  : block read request (level, held until rrdy)
//   addr   : request address, sampled with rrqst/wrqst
//   din    : write data, sampled with wrqst
//   wrqst  : single-word write request (level, held until wacpt)
//   rdacpt : cache accepts the current read beat
//   rrdy   : one-cycle pulse, read request accepted
//   rdrdy  : read beat valid on dout
//   dout   : read beat data
//   wacpt  : one-cycle pulse, write committed
//
// Build option:
//   LC3_DMEM_CRITICAL_WORD_FIRST_EN - when defined, the burst starts at the
//   requested word and wraps within the block; otherwise it starts at
//   offset 0 and ascends.
// ---------------------------------------------------------------------------
module lc3_dmem_ctrl
   import lc3_dmem_pkg::*;
#(
   parameter int ADDR_WD     = DEF_ADDR_WD,
   parameter int DATA_WD     = DEF_DATA_WD,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int READ_LAT    = DEF_READ_LAT,
   parameter int WRITE_LAT   = DEF_WRITE_LAT,
   parameter int MEM_AW      = DEF_MEM_AW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               rrqst,
   input  logic [ADDR_WD-1:0] addr,
   input  logic [DATA_WD-1:0] din,
   input  logic               wrqst,
   input  logic               rdacpt,
   output logic               rrdy,
   output logic               rdrdy,
   output logic [DATA_WD-1:0] dout,
   output logic               wacpt
);

   localparam int BEAT_WD = off_wd(BLOCK_WORDS);
   localparam logic [MEM_AW-1:0]  OFF_MASK  = MEM_AW'(BLOCK_WORDS - 1);
   localparam logic [BEAT_WD-1:0] LAST_BEAT = BEAT_WD'(BLOCK_WORDS - 1);

   // Control state
   dmem_state_t        state_q, state_d;
   logic [LAT_WD-1:0]  lat_q, lat_d;
   logic [BEAT_WD-1:0] beat_q, beat_d;     // beats delivered so far
   logic               rrdy_q, rrdy_d;
   logic               rdrdy_q, rdrdy_d;
   logic               wacpt_q, wacpt_d;

   // Request context (not reset)
   logic [MEM_AW-1:0]  base_q, base_d;
   logic [BEAT_WD-1:0] start_q, start_d;  // offset of the first beat
   logic [MEM_AW-1:0]  waddr_q, waddr_d;
   logic [DATA_WD-1:0] wdata_q, wdata_d;

   // RAM port
   logic               mem_en;
   logic               mem_we;
   logic [MEM_AW-1:0]  mem_addr;
   logic [DATA_WD-1:0] mem_rdata;

   // Offsets wrap inside BEAT_WD bits, so the beat address never carries
   // into the tag bits of base.
   logic [BEAT_WD-1:0] cur_off;
   logic [BEAT_WD-1:0] nxt_off;

   assign cur_off = start_q + beat_q;
   assign nxt_off = start_q + beat_q + BEAT_WD'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
         beat_q  <= '0;
         rrdy_q  <= 1'b0;
         rdrdy_q <= 1'b0;
         wacpt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         rrdy_q  <= rrdy_d;
         rdrdy_q <= rdrdy_d;
         wacpt_q <= wacpt_d;
      end
   end

   always_ff @(posedge clock) begin
      base_q  <= base_d;
      start_q <= start_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      beat_d   = beat_q;
      rrdy_d   = 1'b0;
      rdrdy_d  = rdrdy_q;
      wacpt_d  = 1'b0;
      base_d   = base_q;
      start_d  = start_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = base_q | MEM_AW'(cur_off);

      case (state_q)
         IDLE: begin
            rdrdy_d = 1'b0;
            // A pending store always goes first so writes drain before refills.
            if (wrqst) begin
               waddr_d = addr[MEM_AW-1:0];
               wdata_d = din;
               lat_d   = LAT_WD'(WRITE_LAT - 1);
               state_d = WR_WAIT;
            end else if (rrqst) begin
               rrdy_d = 1'b1;
               base_d = addr[MEM_AW-1:0] & ~OFF_MASK;
               beat_d = '0;
`ifdef LC3_DMEM_CRITICAL_WORD_FIRST_EN
               start_d = addr[BEAT_WD-1:0];
`else
               start_d = '0;
`endif
               // The registered RAM read supplies one cycle of the read
               // latency, so the wait state covers READ_LAT-1 cycles and a
               // latency of 0 or 1 goes straight to the burst.
               if (READ_LAT <= 1) begin
                  state_d = RD_BURST;
               end else begin
                  lat_d   = LAT_WD'(READ_LAT - 2);
                  state_d = RD_WAIT;
               end
            end
         end

         RD_WAIT: begin
            if (lat_q == '0) begin
               state_d = RD_BURST;
            end else begin
               lat_d = lat_q - LAT_WD'(1);
            end
         end

         RD_BURST: begin
            if (!rdrdy_q) begin
               // First fetch of the burst; rdacpt is meaningless until rdrdy.
               mem_en  = 1'b1;
               rdrdy_d = 1'b1;
            end else if (rdacpt) begin
               if (beat_q == LAST_BEAT) begin
                  rdrdy_d = 1'b0;
                  beat_d  = '0;
                  state_d = IDLE;
               end else begin
                  // Fetch the next word now so it is on dout next cycle.
                  beat_d   = beat_q + BEAT_WD'(1);
                  mem_en   = 1'b1;
                  mem_addr = base_q | MEM_AW'(nxt_off);
               end
            end
            // Without rdacpt the RAM is idle, so dout stays put.
         end

         WR_WAIT: begin
            if (lat_q == '0) begin
               // Commit on the way into WR_ACK so a later read sees the data.
               mem_en   = 1'b1;
               mem_we   = 1'b1;
               mem_addr = waddr_q;
               wacpt_d  = 1'b1;
               state_d  = WR_ACK;
            end else begin
               lat_d = lat_q - LAT_WD'(1);
            end
         end

         WR_ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   lc3_dmem_array #(
      .DATA_WD (DATA_WD),
      .MEM_AW  (MEM_AW)
   ) u_array (
      .clock (clock),
      .reset (reset),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   assign rrdy  = rrdy_q;
   assign rdrdy = rdrdy_q;
   assign wacpt = wacpt_q;
   assign dout  = mem_rdata;

endmodule

// File: tb/tb_lc3_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_dmem_ctrl
// Directed bench for lc3_dmem_ctrl. Instance 0 uses default parameters,
// instance 1 is built with READ_LAT=0. Memory contents are loaded through
// the write port.
// ---------------------------------------------------------------------------
module tb_lc3_dmem_ctrl;
   import lc3_dmem_pkg::*;

`ifdef LC3_DMEM_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [15:0] addr;
   logic [15:0] din;
   logic [1:0]  rrqst;
   logic [1:0]  wrqst;
   logic [1:0]  rdacpt;
   wire  [1:0]  rrdy;
   wire  [1:0]  rdrdy;
   wire  [1:0]  wacpt;
   wire  [1:0][15:0] dout;

   int n_checks = 0;
   int n_fail   = 0;

   lc3_dmem_ctrl u_dut (
      .clock  (clock),
      .reset  (reset),
      .rrqst  (rrqst[0]),
      .addr   (addr),
      .din    (din),
      .wrqst  (wrqst[0]),
      .rdacpt (rdacpt[0]),
      .rrdy   (rrdy[0]),
      .rdrdy  (rdrdy[0]),
      .dout   (dout[0]),
      .wacpt  (wacpt[0])
   );

   lc3_dmem_ctrl #(.READ_LAT(0)) u_dut0 (
      .clock  (clock),
      .reset  (reset),
      .rrqst  (rrqst[1]),
      .addr   (addr),
      .din    (din),
      .wrqst  (wrqst[1]),
      .rdacpt (rdacpt[1]),
      .rrdy   (rrdy[1]),
      .rdrdy  (rdrdy[1]),
      .dout   (dout[1]),
      .wacpt  (wacpt[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected beat order for a block whose words are w[0..3] in address order.
   function automatic logic [3:0][15:0] order(input logic [15:0] a, input logic [3:0][15:0] w);
      logic [3:0][15:0] r;
      int off;
      off = CWF ? int'(a[1:0]) : 0;
      for (int b = 0; b < 4; b++) r[b] = w[(off + b) % 4];
      return r;
   endfunction

   task automatic do_write(input int s, input logic [15:0] a, input logic [15:0] d);
      int n;
      addr = a; din = d; wrqst[s] = 1'b1; n = 0;
      do begin tick(); n++; end while (!wacpt[s] && n < 40);
      check("wacpt_lat", n, 3);
      wrqst[s] = 1'b0;
      tick();
      check("wacpt_pulse", wacpt[s], 1'b0);
   endtask

   task automatic start_read(input int s, input logic [15:0] a, input int rrdy_lat, input int rd_lat);
      int n;
      addr = a; rrqst[s] = 1'b1; rdacpt[s] = 1'b1; n = 0;
      do begin tick(); n++; end while (!rrdy[s] && n < 40);
      check("rrdy_lat", n, rrdy_lat);
      rrqst[s] = 1'b0; n = 0;
      do begin
         tick(); n++;
         if (n == 1) check("rrdy_pulse", rrdy[s], 1'b0);
      end while (!rdrdy[s] && n < 40);
      check("rdrdy_lat", n, rd_lat);
   endtask

   task automatic read_beats(input int s, input logic [3:0][15:0] e, input int stall_beat, input int stall_n);
      for (int b = 0; b < 4; b++) begin
         check("beat_data", dout[s], e[b]);
         check("beat_vld", rdrdy[s], 1'b1);
         if (b == stall_beat) begin
            rdacpt[s] = 1'b0;
            for (int k = 0; k < stall_n; k++) begin
               tick();
               check("stall_data", dout[s], e[b]);
               check("stall_vld", rdrdy[s], 1'b1);
            end
            rdacpt[s] = 1'b1;
         end
         tick();
      end
      check("burst_end", rdrdy[s], 1'b0);
      check("dout_hold", dout[s], e[3]);
      rdacpt[s] = 1'b0;
   endtask

   task automatic do_read(input int s, input logic [15:0] a, input logic [3:0][15:0] w,
                          input int rd_lat, input int stall_beat, input int stall_n);
      start_read(s, a, 1, rd_lat);
      read_beats(s, order(a, w), stall_beat, stall_n);
   endtask

   initial begin
      reset = 1'b1; addr = '0; din = '0;
      rrqst = '0; wrqst = '0; rdacpt = '0;
      tick(); tick();
      check("rst_rrdy",  rrdy[0],  1'b0);
      check("rst_rdrdy", rdrdy[0], 1'b0);
      check("rst_wacpt", wacpt[0], 1'b0);
      check("rst_dout",  dout[0],  16'h0000);
      check("rst_dout0", dout[1],  16'h0000);
      check("rst_state", u_dut.state_q, IDLE);
      reset = 1'b0;
      tick();

      // Load block 3000..3003
      do_write(0, 16'h3000, 16'hA000);
      do_write(0, 16'h3001, 16'hA001);
      do_write(0, 16'h3002, 16'hA002);
      do_write(0, 16'h3003, 16'hA003);

      // Plain refill, rdacpt held high
      do_read(0, 16'h3002, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 4, -1, 0);

      // Refill with beat 1 stalled for three cycles
      do_read(0, 16'h3002, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 4, 1, 3);

      // Write-through then read back the block
      do_write(0, 16'h3001, 16'hBEEF);
      do_read(0, 16'h3000, {16'hA003, 16'hA002, 16'hBEEF, 16'hA000}, 4, -1, 0);

      // Write and read requested together: write wins
      begin
         int n;
         addr = 16'h3003; din = 16'h1234; wrqst[0] = 1'b1; rrqst[0] = 1'b1; n = 0;
         do begin tick(); n++; end while (!wacpt[0] && n < 40);
         check("both_wacpt_lat", n, 3);
         check("both_no_rrdy", rrdy[0], 1'b0);
         wrqst[0] = 1'b0;
         start_read(0, 16'h3003, 2, 4);
         read_beats(0, order(16'h3003, {16'h1234, 16'hA002, 16'hBEEF, 16'hA000}), -1, 0);
      end
      tick();

      // Asynchronous reset during beat 2
      start_read(0, 16'h3000, 1, 4);
      tick(); tick();
      check("pre_rst_beat2", dout[0], 16'hA002);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_rdrdy", rdrdy[0], 1'b0);
      check("mid_rst_rrdy",  rrdy[0],  1'b0);
      check("mid_rst_wacpt", wacpt[0], 1'b0);
      check("mid_rst_dout",  dout[0],  16'h0000);
      check("mid_rst_state", u_dut.state_q, IDLE);
      rdacpt[0] = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      do_read(0, 16'h3000, {16'h1234, 16'hA002, 16'hBEEF, 16'hA000}, 4, -1, 0);

      // Reset while a write waits: the write must not land
      addr = 16'h3000; din = 16'h5555; wrqst[0] = 1'b1;
      tick();
      check("abort_wr_state", u_dut.state_q, WR_WAIT);
      #2 reset = 1'b1; wrqst[0] = 1'b0;
      #1;
      check("abort_wacpt", wacpt[0], 1'b0);
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check("abort_no_wacpt", wacpt[0], 1'b0);
      do_read(0, 16'h3000, {16'h1234, 16'hA002, 16'hBEEF, 16'hA000}, 4, -1, 0);

      // READ_LAT=0 instance: top-of-memory block, no wrap into 0000
      do_write(1, 16'h0000, 16'hD000);
      do_write(1, 16'h0001, 16'hD001);
      do_write(1, 16'hFFFC, 16'hC000);
      do_write(1, 16'hFFFD, 16'hC001);
      do_write(1, 16'hFFFE, 16'hC002);
      do_write(1, 16'hFFFF, 16'hC003);
      do_read(1, 16'hFFFE, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 1, -1, 0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
